// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullsub_bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module fullsub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gnd,
  input  logic             vdd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             sbit,
  output logic             sbit_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Power pins exist only so netlists with explicit supplies still connect.
  logic unused_pwr;
  assign unused_pwr = gnd ^ vdd;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              d_bit, bout_bit;

  fullsub_bit u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        // diff is left untouched so the previous result survives until RUN.
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        borrow_d = bout_bit;
        // Counter saturates on the last bit instead of wrapping.
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign sbit_valid = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign sbit       = sbit_valid & d_bit;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed + randomized checks of serial_sub against an arithmetic model.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, sbit, sbit_valid, out_valid, borrow_out;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] held_diff;
  logic         held_borrow;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gnd        (1'b0),
    .vdd        (1'b1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sbit       (sbit),
    .sbit_valid (sbit_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
    chk({tag, ".out_valid"},  32'(out_valid),  32'd0);
    chk({tag, ".sbit_valid"}, 32'(sbit_valid), 32'd0);
    chk({tag, ".sbit"},       32'(sbit),       32'd0);
    chk({tag, ".diff"},       32'(diff),       32'd0);
    chk({tag, ".borrow"},     32'(borrow_out), 32'd0);
  endtask

  // Accept one operand pair, check every serial bit, end sitting in DONE.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] exp_d;
    logic         exp_b;
    exp_d = x - y;
    exp_b = (x < y);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    chk("accept.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);  // operands must be irrelevant now
    for (int i = 0; i < W; i++) begin
      chk($sformatf("run%0d.sbit_valid", i), 32'(sbit_valid), 32'd1);
      chk($sformatf("run%0d.sbit", i),       32'(sbit),       32'(exp_d[i]));
      chk($sformatf("run%0d.out_valid", i),  32'(out_valid),  32'd0);
      @(negedge clk);
    end
    chk("done.out_valid",  32'(out_valid),  32'd1);
    chk("done.sbit_valid", 32'(sbit_valid), 32'd0);
    chk("done.in_ready",   32'(in_ready),   32'd0);
    chk("done.diff",       32'(diff),       32'(exp_d));
    chk("done.borrow",     32'(borrow_out), 32'(exp_b));
    held_diff   = exp_d;
    held_borrow = exp_b;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle.in_ready",  32'(in_ready),   32'd1);
    chk("idle.out_valid", 32'(out_valid),  32'd0);
    chk("idle.diff_kept", 32'(diff),       32'(held_diff));
    chk("idle.borrow",    32'(borrow_out), 32'(held_borrow));
  endtask

  initial begin
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h23); finish_op();
    do_op(8'h00, 8'h01); finish_op();
    do_op(8'hFF, 8'hFF); finish_op();

    // Result held in DONE while out_ready is low and new operands are offered.
    do_op(8'hC3, 8'h5E);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready",  32'(in_ready),  32'd0);
      chk("hold.diff",      32'(diff),      32'(held_diff));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold.exit_no_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Reset pulsed while bit 3 is being computed.
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst.sbit_valid", 32'(sbit_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun_rst");
    #1 rst_n = 1'b1;
    do_op(8'h10, 8'h01); finish_op();

    // Back-to-back operations.
    do_op(8'h80, 8'h7F); finish_op();
    do_op(8'h7F, 8'h80); finish_op();

    for (int n = 0; n < 12; n++) begin
      do_op(W'($urandom), W'($urandom));
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
